input_cache_ctrl: RTL

Sequencer for the TPU input cache, a row-addressed SRAM-style store of A rows × N 32-bit words with a 1-cycle registered row read. The controller accepts load and feed commands. A load streams words from the host into a contiguous row range. A feed reads a contiguous row range out to the systolic-array front end, one full row per handshake. It is the only master of the cache port and owns all of its control signals.

---
 rtl/tpu_pkg.sv | 20 ++
 rtl/cache_addr_counter.sv | 43 ++++
 rtl/input_cache_ctrl.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/tpu_pkg.sv
// Shared TPU definitions: controller state encoding, command opcodes and
// default address widths.
package tpu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_LOAD     = 2'd1,
        ST_FEED_RD  = 2'd2,
        ST_FEED_OUT = 2'd3
    } state_t;

    localparam logic OP_LOAD = 1'b0;
    localparam logic OP_FEED = 1'b1;

    localparam int unsigned A_DEF  = 60000;
    localparam int unsigned N_DEF  = 256;
    localparam int unsigned AW_DEF = 16;
    localparam int unsigned NW_DEF = 8;

endpackage

// File: rtl/cache_addr_counter.sv
// Row/column position counter shared by load and feed sequencing.
// In row_only mode each increment advances a whole row.
module cache_addr_counter #(
    parameter int unsigned N  = 256,
    parameter int unsigned AW = 16,
    parameter int unsigned NW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr_i,
    input  logic          inc_i,
    input  logic          row_only_i,
    input  logic [AW-1:0] rows_i,
    output logic [AW-1:0] row_cnt_o,
    output logic [NW-1:0] col_cnt_o,
    output logic          last_o
);

    logic [AW-1:0] row_q;
    logic [NW-1:0] col_q;
    logic          col_wrap;

    assign col_wrap = (col_q == NW'(N - 1));

    always_ff @(posedge clk) begin
        if (rst || clr_i) begin
            row_q <= '0;
            col_q <= '0;
        end else if (inc_i) begin
            if (row_only_i || col_wrap) begin
                row_q <= row_q + AW'(1);
                col_q <= '0;
            end else begin
                col_q <= col_q + NW'(1);
            end
        end
    end

    assign row_cnt_o = row_q;
    assign col_cnt_o = col_q;
    assign last_o    = (row_q == rows_i - AW'(1)) && (row_only_i || col_wrap);

endmodule

// File: rtl/input_cache_ctrl.sv
// Input cache sequencer: streams host words into a row range (LOAD) and
// presents a row range to the systolic array one row per handshake (FEED).
module input_cache_ctrl
    import tpu_pkg::*;
#(
    parameter int unsigned A  = A_DEF,
    parameter int unsigned N  = N_DEF,
    parameter int unsigned AW = AW_DEF,
    parameter int unsigned NW = NW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_op,
    input  logic [AW-1:0] cmd_base,
    input  logic [AW-1:0] cmd_rows,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [31:0]   s_data,
    output logic          cache_en,
    output logic          cache_wr,
    output logic [AW-1:0] cache_sel_a,
    output logic [NW-1:0] cache_sel_n,
    output logic [31:0]   cache_wdata,
    output logic          row_valid,
    input  logic          row_ready,
    output logic [AW-1:0] row_index,
    output logic          busy,
    output logic          done,
    output logic          err
);

    state_t        state_q;
    logic [AW-1:0] base_q;
    logic [AW-1:0] rows_q;
    logic          done_q;
    logic          err_q;
    logic          row_valid_q;
    logic [AW-1:0] row_index_q;

    logic [AW-1:0] row_cnt;
    logic [NW-1:0] col_cnt;
    logic          last;
    logic [AW:0]   cmd_end;
    logic          cmd_bad;
    logic          accept;
    logic          load_hs;
    logic          feed_hs;
    logic [AW-1:0] cur_row;
    logic [AW-1:0] nxt_row;

    assign cmd_end = {1'b0, cmd_base} + {1'b0, cmd_rows};
    assign cmd_bad = (cmd_rows == '0) || (cmd_end > (AW+1)'(A));
    assign accept  = (state_q == ST_IDLE) && cmd_valid;
    assign load_hs = (state_q == ST_LOAD) && s_valid;
    assign feed_hs = (state_q == ST_FEED_OUT) && row_ready;
    assign cur_row = base_q + row_cnt;
    assign nxt_row = cur_row + AW'(1);

    cache_addr_counter #(.N(N), .AW(AW), .NW(NW)) u_cnt (
        .clk        (clk),
        .rst        (rst),
        .clr_i      (accept && !cmd_bad),
        .inc_i      (load_hs || feed_hs),
        .row_only_i (state_q != ST_LOAD),
        .rows_i     (rows_q),
        .row_cnt_o  (row_cnt),
        .col_cnt_o  (col_cnt),
        .last_o     (last)
    );

    // Cache strobes are combinational so writes and follow-on reads land on the handshake edge.
    always_comb begin
        cache_en    = 1'b0;
        cache_wr    = 1'b0;
        cache_sel_a = '0;
        cache_sel_n = '0;
        cache_wdata = '0;
        if (load_hs) begin
            cache_en    = 1'b1;
            cache_wr    = 1'b1;
            cache_sel_a = cur_row;
            cache_sel_n = col_cnt;
            cache_wdata = s_data;
        end else if (state_q == ST_FEED_RD) begin
            cache_en    = 1'b1;
            cache_sel_a = cur_row;
        end else if (feed_hs && !last) begin
            cache_en    = 1'b1;
            cache_sel_a = nxt_row;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            base_q      <= '0;
            rows_q      <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            row_valid_q <= 1'b0;
            row_index_q <= '0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        if (cmd_bad) begin
                            err_q <= 1'b1;
                        end else begin
                            base_q  <= cmd_base;
                            rows_q  <= cmd_rows;
                            state_q <= (cmd_op == OP_FEED) ? ST_FEED_RD : ST_LOAD;
                        end
                    end
                end
                ST_LOAD: begin
                    if (load_hs && last) begin
                        state_q <= ST_IDLE;
                        done_q  <= 1'b1;
                    end
                end
                ST_FEED_RD: begin
                    state_q     <= ST_FEED_OUT;
                    row_valid_q <= 1'b1;
                    row_index_q <= cur_row;
                end
                ST_FEED_OUT: begin
                    if (row_ready) begin
                        if (last) begin
                            state_q     <= ST_IDLE;
                            done_q      <= 1'b1;
                            row_valid_q <= 1'b0;
                            row_index_q <= '0;
                        end else begin
                            row_index_q <= nxt_row;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign cmd_ready = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign s_ready   = (state_q == ST_LOAD);
    assign done      = done_q;
    assign err       = err_q;
    assign row_valid = row_valid_q;
    assign row_index = row_index_q;

endmodule
